// File: rtl/reorder_buffer_pkg.sv
// reorder_buffer_pkg
//   Definitions shared by the reorder buffer, the register file and the
//   reservation stations:
//     ROB_ENTRY_WIDTH - width of a ROB tag (tag 0 means "no entry")
//     TAG_NONE        - the reserved "no entry" tag value
//     rob_entry_t     - field layout of one reorder-buffer entry
package reorder_buffer_pkg;

    localparam int ROB_ENTRY_WIDTH = 5;
    localparam int DR_WIDTH        = 5;
    localparam int DATA_WIDTH      = 32;

    localparam logic [ROB_ENTRY_WIDTH-1:0] TAG_NONE = '0;

    typedef struct packed {
        logic                  busy;
        logic                  ready;
        logic [DR_WIDTH-1:0]   dr_index;
        logic [DATA_WIDTH-1:0] data;
    } rob_entry_t;

endpackage

// File: rtl/reorder_buffer.sv
// reorder_buffer
//   In-order retirement queue for an out-of-order core. Issue allocates an
//   entry at the tail, the common data bus (CDB) fills results in, and the
//   head entry retires to the register file once its result is present.
//
//   Ports
//     clk, rst                 clock, synchronous active-low reset
//     Alloc_Valid/Ready        allocation handshake, Alloc_DRindex = dest reg,
//                              Alloc_ROBEN = tag the allocation receives
//     CDB_Valid/ROBEN/Data     result broadcast
//     Flush                    drop every in-flight entry
//     RP_ROBEN1/2              operand tags queried by issue
//     RP_Ready1/2, RP_Data1/2  operand forwarding results
//     Commit_Valid             head entry retires this cycle
//     WP1_ROBEN/DRindex/Data   register-file write port (zero when idle)
//     Full, Empty              occupancy flags
//
//   Handshake: an allocation happens on a rising edge where Alloc_Valid and
//   Alloc_Ready are both high; Alloc_Ready reflects occupancy before any
//   commit in the same cycle, so a full buffer stalls even while retiring.
module reorder_buffer
    import reorder_buffer_pkg::*;
#(
    parameter int ROB_Entry_WIDTH = ROB_ENTRY_WIDTH
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       Alloc_Valid,
    input  logic [4:0]                 Alloc_DRindex,
    output logic                       Alloc_Ready,
    output logic [ROB_Entry_WIDTH-1:0] Alloc_ROBEN,
    input  logic                       CDB_Valid,
    input  logic [ROB_Entry_WIDTH-1:0] CDB_ROBEN,
    input  logic [31:0]                CDB_Data,
    input  logic                       Flush,
    input  logic [ROB_Entry_WIDTH-1:0] RP_ROBEN1,
    input  logic [ROB_Entry_WIDTH-1:0] RP_ROBEN2,
    output logic                       RP_Ready1,
    output logic                       RP_Ready2,
    output logic [31:0]                RP_Data1,
    output logic [31:0]                RP_Data2,
    output logic                       Commit_Valid,
    output logic [ROB_Entry_WIDTH-1:0] WP1_ROBEN,
    output logic [4:0]                 WP1_DRindex,
    output logic [31:0]                WP1_Data,
    output logic                       Full,
    output logic                       Empty
);

    localparam int W     = ROB_Entry_WIDTH;
    localparam int SLOTS = 1 << W;
    // Highest tag; also the capacity, since tag 0 is never handed out.
    localparam logic [W-1:0] LAST_TAG = {W{1'b1}};
    localparam logic [W-1:0] NO_TAG   = W'(TAG_NONE);
    localparam logic [W-1:0] FIRST_TAG = W'(1);

    rob_entry_t     entries [SLOTS];
    logic [W-1:0]   head;
    logic [W-1:0]   tail;
    logic [W-1:0]   count;
    rob_entry_t     head_entry;
    logic           alloc_fire;
    logic           cdb_hit;

    // Pointers step 1..LAST_TAG and wrap back to 1, skipping the reserved tag.
    function automatic logic [W-1:0] next_tag(input logic [W-1:0] t);
        return (t == LAST_TAG) ? FIRST_TAG : t + W'(1);
    endfunction

    // Operand lookup: a completed entry wins, then a same-cycle CDB result.
    function automatic logic [32:0] lookup(input logic [W-1:0] tag,
                                           input rob_entry_t   e,
                                           input logic         cdb_valid,
                                           input logic [W-1:0] cdb_tag,
                                           input logic [31:0]  cdb_data);
        if (tag == NO_TAG)
            return 33'd0;
        else if (e.busy && e.ready)
            return {1'b1, e.data};
        else if (cdb_valid && cdb_tag == tag)
            return {1'b1, cdb_data};
        else
            return 33'd0;
    endfunction

    assign Full        = (count == LAST_TAG);
    assign Empty       = (count == '0);
    assign Alloc_Ready = !Full;
    assign Alloc_ROBEN = tail;

    assign head_entry   = entries[head];
    assign Commit_Valid = head_entry.busy && head_entry.ready && !Flush;
    assign WP1_ROBEN    = Commit_Valid ? head : '0;
    assign WP1_DRindex  = Commit_Valid ? head_entry.dr_index : '0;
    assign WP1_Data     = Commit_Valid ? head_entry.data : '0;

    assign alloc_fire = Alloc_Valid && !Full;
    assign cdb_hit    = CDB_Valid && (CDB_ROBEN != NO_TAG) && entries[CDB_ROBEN].busy;

    always_comb begin
        {RP_Ready1, RP_Data1} = lookup(RP_ROBEN1, entries[RP_ROBEN1],
                                       CDB_Valid, CDB_ROBEN, CDB_Data);
    end

    always_comb begin
        {RP_Ready2, RP_Data2} = lookup(RP_ROBEN2, entries[RP_ROBEN2],
                                       CDB_Valid, CDB_ROBEN, CDB_Data);
    end

    // Alloc, CDB and commit never hit the same slot in a way that conflicts:
    // the tail slot is not busy unless the buffer is full (no alloc), and a
    // CDB write to the committing head is discarded along with the entry.
    always_ff @(posedge clk) begin
        if (!rst) begin
            head  <= FIRST_TAG;
            tail  <= FIRST_TAG;
            count <= '0;
            for (int i = 0; i < SLOTS; i++)
                entries[i] <= '0;
        end else if (Flush) begin
            head  <= FIRST_TAG;
            tail  <= FIRST_TAG;
            count <= '0;
            for (int i = 0; i < SLOTS; i++) begin
                entries[i].busy  <= 1'b0;
                entries[i].ready <= 1'b0;
            end
        end else begin
            if (alloc_fire) begin
                entries[tail] <= rob_entry_t'{busy: 1'b1, ready: 1'b0,
                                              dr_index: Alloc_DRindex, data: 32'd0};
                tail <= next_tag(tail);
            end
            if (cdb_hit) begin
                entries[CDB_ROBEN].ready <= 1'b1;
                entries[CDB_ROBEN].data  <= CDB_Data;
            end
            if (Commit_Valid) begin
                entries[head].busy  <= 1'b0;
                entries[head].ready <= 1'b0;
                head <= next_tag(head);
            end
            count <= count + W'(alloc_fire) - W'(Commit_Valid);
        end
    end

endmodule

// File: tb/tb_reorder_buffer.sv
module tb_reorder_buffer;

    logic        clk = 1'b0;
    logic        rst;
    logic        Alloc_Valid;
    logic [4:0]  Alloc_DRindex;
    logic        Alloc_Ready;
    logic [4:0]  Alloc_ROBEN;
    logic        CDB_Valid;
    logic [4:0]  CDB_ROBEN;
    logic [31:0] CDB_Data;
    logic        Flush;
    logic [4:0]  RP_ROBEN1;
    logic [4:0]  RP_ROBEN2;
    logic        RP_Ready1;
    logic        RP_Ready2;
    logic [31:0] RP_Data1;
    logic [31:0] RP_Data2;
    logic        Commit_Valid;
    logic [4:0]  WP1_ROBEN;
    logic [4:0]  WP1_DRindex;
    logic [31:0] WP1_Data;
    logic        Full;
    logic        Empty;

    int total = 0;
    int bad   = 0;

    reorder_buffer #(.ROB_Entry_WIDTH(5)) dut (
        .clk(clk), .rst(rst),
        .Alloc_Valid(Alloc_Valid), .Alloc_DRindex(Alloc_DRindex),
        .Alloc_Ready(Alloc_Ready), .Alloc_ROBEN(Alloc_ROBEN),
        .CDB_Valid(CDB_Valid), .CDB_ROBEN(CDB_ROBEN), .CDB_Data(CDB_Data),
        .Flush(Flush),
        .RP_ROBEN1(RP_ROBEN1), .RP_ROBEN2(RP_ROBEN2),
        .RP_Ready1(RP_Ready1), .RP_Ready2(RP_Ready2),
        .RP_Data1(RP_Data1), .RP_Data2(RP_Data2),
        .Commit_Valid(Commit_Valid),
        .WP1_ROBEN(WP1_ROBEN), .WP1_DRindex(WP1_DRindex), .WP1_Data(WP1_Data),
        .Full(Full), .Empty(Empty)
    );

    // clock
    always #5 clk = ~clk;

    // Inputs change 1 time unit after a rising edge; checks run 1 more unit
    // later, well away from the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic idle_inputs();
        Alloc_Valid   = 1'b0;
        Alloc_DRindex = 5'd0;
        CDB_Valid     = 1'b0;
        CDB_ROBEN     = 5'd0;
        CDB_Data      = 32'd0;
        Flush         = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b0;
        tick();
        rst = 1'b1;
    endtask

    task automatic alloc(input logic [4:0] dr);
        Alloc_Valid   = 1'b1;
        Alloc_DRindex = dr;
        tick();
        Alloc_Valid   = 1'b0;
    endtask

    task automatic check_reset_values(input string tag);
        settle();
        chk({tag, "_empty"},  32'(Empty), 32'd1);
        chk({tag, "_full"},   32'(Full), 32'd0);
        chk({tag, "_aready"}, 32'(Alloc_Ready), 32'd1);
        chk({tag, "_aroben"}, 32'(Alloc_ROBEN), 32'd1);
        chk({tag, "_cv"},     32'(Commit_Valid), 32'd0);
        chk({tag, "_wproben"}, 32'(WP1_ROBEN), 32'd0);
        chk({tag, "_wpdr"},   32'(WP1_DRindex), 32'd0);
        chk({tag, "_wpdata"}, WP1_Data, 32'd0);
        chk({tag, "_rp1"},    32'(RP_Ready1), 32'd0);
        chk({tag, "_rp2"},    32'(RP_Ready2), 32'd0);
    endtask

    initial begin
        rst       = 1'b0;
        RP_ROBEN1 = 5'd0;
        RP_ROBEN2 = 5'd0;
        idle_inputs();
        #1;

        // ---- reset state
        do_reset();
        RP_ROBEN1 = 5'd1;
        RP_ROBEN2 = 5'd2;
        check_reset_values("rst");

        // ---- basic alloc / out-of-order CDB / in-order commit
        Alloc_Valid = 1'b1; Alloc_DRindex = 5'd3; settle();
        chk("alloc1_tag", 32'(Alloc_ROBEN), 32'd1);
        tick();
        Alloc_DRindex = 5'd7; settle();
        chk("alloc2_tag", 32'(Alloc_ROBEN), 32'd2);
        tick();
        Alloc_Valid = 1'b0; settle();
        chk("two_empty", 32'(Empty), 32'd0);
        chk("two_tail", 32'(Alloc_ROBEN), 32'd3);

        CDB_Valid = 1'b1; CDB_ROBEN = 5'd2; CDB_Data = 32'hBEEF; settle();
        chk("cdb2_cv_same", 32'(Commit_Valid), 32'd0);
        tick();
        CDB_ROBEN = 5'd1; CDB_Data = 32'h11; settle();
        chk("cdb2_cv_after", 32'(Commit_Valid), 32'd0);
        chk("cdb1_no_bypass", 32'(Commit_Valid), 32'd0);
        tick();
        CDB_Valid = 1'b0; settle();
        chk("c1_cv", 32'(Commit_Valid), 32'd1);
        chk("c1_roben", 32'(WP1_ROBEN), 32'd1);
        chk("c1_dr", 32'(WP1_DRindex), 32'd3);
        chk("c1_data", WP1_Data, 32'h11);
        tick();
        chk("c2_cv", 32'(Commit_Valid), 32'd1);
        chk("c2_roben", 32'(WP1_ROBEN), 32'd2);
        chk("c2_dr", 32'(WP1_DRindex), 32'd7);
        chk("c2_data", WP1_Data, 32'hBEEF);
        tick();
        chk("drain_empty", 32'(Empty), 32'd1);
        chk("drain_cv", 32'(Commit_Valid), 32'd0);
        chk("drain_wpdata", WP1_Data, 32'd0);

        // ---- fill to capacity, ignored alloc, wrap reuse of tag 1
        do_reset();
        for (int i = 1; i <= 31; i++) begin
            settle();
            chk("fill_tag", 32'(Alloc_ROBEN), 32'(i));
            alloc(5'(i));
        end
        chk("full_flag", 32'(Full), 32'd1);
        chk("full_aready", 32'(Alloc_Ready), 32'd0);
        chk("full_tail", 32'(Alloc_ROBEN), 32'd1);
        alloc(5'd9);
        chk("full_ignored_tail", 32'(Alloc_ROBEN), 32'd1);
        chk("full_ignored_full", 32'(Full), 32'd1);

        CDB_Valid = 1'b1; CDB_ROBEN = 5'd1; CDB_Data = 32'hA1;
        tick();
        CDB_Valid = 1'b0;
        // commit and alloc together while full: alloc must stall
        Alloc_Valid = 1'b1; Alloc_DRindex = 5'd20; settle();
        chk("full_commit_cv", 32'(Commit_Valid), 32'd1);
        chk("full_commit_dr", 32'(WP1_DRindex), 32'd1);
        chk("full_commit_data", WP1_Data, 32'hA1);
        tick();
        Alloc_Valid = 1'b0; settle();
        chk("stall_full", 32'(Full), 32'd0);
        chk("stall_tail", 32'(Alloc_ROBEN), 32'd1);
        alloc(5'd20);
        chk("wrap_full", 32'(Full), 32'd1);
        chk("wrap_tail", 32'(Alloc_ROBEN), 32'd2);

        // ---- operand forwarding
        do_reset();
        for (int i = 1; i <= 4; i++) alloc(5'(i + 10));
        RP_ROBEN1 = 5'd4; RP_ROBEN2 = 5'd0;
        CDB_Valid = 1'b1; CDB_ROBEN = 5'd4; CDB_Data = 32'h55; settle();
        chk("rp_bypass_rdy", 32'(RP_Ready1), 32'd1);
        chk("rp_bypass_data", RP_Data1, 32'h55);
        tick();
        CDB_ROBEN = 5'd0; CDB_Data = 32'h99; settle();
        chk("rp_entry_rdy", 32'(RP_Ready1), 32'd1);
        chk("rp_entry_data", RP_Data1, 32'h55);
        chk("rp_tag0_rdy", 32'(RP_Ready2), 32'd0);
        chk("rp_tag0_data", RP_Data2, 32'd0);
        tick();
        CDB_ROBEN = 5'd9; CDB_Data = 32'h77;
        tick();
        CDB_Valid = 1'b0;
        RP_ROBEN2 = 5'd9; settle();
        chk("rp_nonbusy_rdy", 32'(RP_Ready2), 32'd0);
        RP_ROBEN2 = 5'd3; settle();
        chk("rp_pending_rdy", 32'(RP_Ready2), 32'd0);
        chk("rp_pending_data", RP_Data2, 32'd0);

        // ---- flush with 5 entries and a ready head
        alloc(5'd15);
        CDB_Valid = 1'b1; CDB_ROBEN = 5'd1; CDB_Data = 32'h1234;
        tick();
        CDB_Valid = 1'b0; settle();
        chk("pre_flush_cv", 32'(Commit_Valid), 32'd1);
        Flush = 1'b1; Alloc_Valid = 1'b1; settle();
        chk("flush_cv", 32'(Commit_Valid), 32'd0);
        chk("flush_wproben", 32'(WP1_ROBEN), 32'd0);
        tick();
        Flush = 1'b0; Alloc_Valid = 1'b0; settle();
        chk("post_flush_empty", 32'(Empty), 32'd1);
        chk("post_flush_tag", 32'(Alloc_ROBEN), 32'd1);
        chk("post_flush_rp", 32'(RP_Ready1), 32'd0);

        // ---- reset during simultaneous alloc + CDB + commit
        alloc(5'd5);
        alloc(5'd6);
        CDB_Valid = 1'b1; CDB_ROBEN = 5'd1; CDB_Data = 32'hCAFE;
        tick();
        CDB_ROBEN = 5'd2; CDB_Data = 32'hF00D;
        Alloc_Valid = 1'b1; Alloc_DRindex = 5'd8;
        rst = 1'b0; settle();
        chk("burst_cv", 32'(Commit_Valid), 32'd1);
        tick();
        rst = 1'b1;
        idle_inputs();
        RP_ROBEN1 = 5'd1;
        RP_ROBEN2 = 5'd2;
        check_reset_values("midrst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Hard time limit so the run always ends.
    initial begin
        #100000;
        bad++;
        $display("FAIL timeout observed=running expected=finished");
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
